// File: rtl/gesture_cmd_scheduler_if.sv
// Command handshake between the gesture scheduler (master) and the servo
// command path (slave).
interface gesture_cmd_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;

    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/gesture_cmd_scheduler.sv
// Debounces per-frame finger counts and issues each new stable gesture once,
// then holds off for a number of frames. Define GESTURE_WATCHDOG_EN for the HOME watchdog.
module gesture_cmd_scheduler #(
    parameter int STABLE_FRAMES  = 4,
    parameter int HOLDOFF_FRAMES = 8,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            count_valid,
    input  logic [2:0]                      finger_count,
    input  logic                            hand_detected,
    gesture_cmd_scheduler_if.master         cmd,
    output logic                            busy,
    output logic                            timeout_flag
);
    localparam int RW = $clog2(STABLE_FRAMES + 1);
    localparam int HW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [2:0] HOME = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ISSUE, S_HOLDOFF} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cand_q, cand_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic [2:0]    last_cmd_q, last_cmd_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [2:0]    cmd_code_q, cmd_code_d;
    logic [2:0]    samp;
    logic [RW-1:0] run_inc;

`ifdef GESTURE_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_flag_q, timeout_flag_d;
`endif

    assign samp    = !hand_detected ? HOME : ((finger_count > 3'd5) ? 3'd5 : finger_count);
    assign run_inc = (run_cnt_q == RW'(STABLE_FRAMES)) ? run_cnt_q : run_cnt_q + RW'(1);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        run_cnt_d   = run_cnt_q;
        last_cmd_d  = last_cmd_q;
        hold_cnt_d  = hold_cnt_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_TRACK;
            end
            S_TRACK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (count_valid) begin
                    cand_d    = samp;
                    run_cnt_d = (samp == cand_q) ? run_inc : RW'(1);
                    if (run_cnt_d == RW'(STABLE_FRAMES) && samp != last_cmd_q) begin
                        state_d     = S_ISSUE;
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = samp;
                    end
                end
            end
            S_ISSUE: begin
                // enable is only honoured once the offered command is accepted
                if (cmd.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    last_cmd_d  = cmd_code_q;
                    run_cnt_d   = '0;
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (HOLDOFF_FRAMES == 0) begin
                        state_d = S_TRACK;
                    end else begin
                        state_d    = S_HOLDOFF;
                        hold_cnt_d = HW'(HOLDOFF_FRAMES);
                    end
                end
            end
            S_HOLDOFF: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (count_valid) begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                    if (hold_cnt_q == HW'(1)) state_d = S_TRACK;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef GESTURE_WATCHDOG_EN
        wd_cnt_d       = wd_cnt_q;
        timeout_flag_d = timeout_flag_q;
        if (count_valid) timeout_flag_d = 1'b0;
        // a count_valid in the trip cycle takes priority and just clears the counter
        if (enable && (state_q == S_TRACK || state_q == S_HOLDOFF)) begin
            if (count_valid) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q == WW'(TIMEOUT_CYCLES - 1)) begin
                wd_cnt_d       = '0;
                timeout_flag_d = 1'b1;
                run_cnt_d      = '0;
                if (last_cmd_q != HOME) begin
                    state_d     = S_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = HOME;
                end else begin
                    state_d = S_TRACK;
                end
            end else begin
                wd_cnt_d = wd_cnt_q + WW'(1);
            end
        end else begin
            wd_cnt_d = '0;
        end
`endif

        if (state_d == S_IDLE) run_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cand_q      <= HOME;
            run_cnt_q   <= '0;
            last_cmd_q  <= HOME;
            hold_cnt_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= HOME;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            run_cnt_q   <= run_cnt_d;
            last_cmd_q  <= last_cmd_d;
            hold_cnt_q  <= hold_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
        end
    end

`ifdef GESTURE_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            wd_cnt_q       <= wd_cnt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end
    assign timeout_flag = timeout_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_code  = cmd_code_q;
    assign busy          = (state_q == S_ISSUE) || (state_q == S_HOLDOFF);
endmodule

// File: tb/tb_gesture_cmd_scheduler.sv
// Directed table-driven bench for gesture_cmd_scheduler (STABLE=4, HOLDOFF=8,
// TIMEOUT=100), plus a watchdog sequence whose expectation follows GESTURE_WATCHDOG_EN.
module tb_gesture_cmd_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       count_valid;
    logic [2:0] finger_count;
    logic       hand_detected;
    logic       busy;
    logic       timeout_flag;

    gesture_cmd_scheduler_if cif ();

    gesture_cmd_scheduler #(
        .STABLE_FRAMES (4),
        .HOLDOFF_FRAMES(8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .count_valid  (count_valid),
        .finger_count (finger_count),
        .hand_detected(hand_detected),
        .cmd          (cif),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit       cv;
        bit [2:0] fc;
        bit       hd;
        bit       rdy;
        bit       ev;
        bit [2:0] ec;
        bit       eb;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(int en, int cv, int fc, int hd, int rdy, int ev, int ec, int eb);
        vec_t v;
        v.en = en[0]; v.cv = cv[0]; v.fc = fc[2:0]; v.hd = hd[0]; v.rdy = rdy[0];
        v.ev = ev[0]; v.ec = ec[2:0]; v.eb = eb[0];
        vecs.push_back(v);
    endfunction

    function automatic void addn(int n, int en, int cv, int fc, int hd, int rdy, int ev, int ec, int eb);
        for (int i = 0; i < n; i++) add(en, cv, fc, hd, rdy, ev, ec, eb);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit en, input bit cv, input bit [2:0] fc, input bit hd, input bit rdy);
        @(negedge clk);
        enable = en; count_valid = cv; finger_count = fc; hand_detected = hd; cif.cmd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int trip;
        int tv;
        int tc;

        // first command: four frames of 3, ready already high
        add(1,0,0,0,1, 0,7,0);
        addn(3, 1,1,3,1,1, 0,7,0);
        add(1,1,3,1,1, 1,3,1);
        add(1,0,0,0,1, 0,3,1);
        // hold-off: 8 frames of 5 are discarded, then 4 frames of 5 issue it
        addn(7, 1,1,5,1,1, 0,3,1);
        add(1,1,5,1,1, 0,3,0);
        addn(3, 1,1,5,1,1, 0,3,0);
        add(1,1,5,1,1, 1,5,1);
        // frame coinciding with the handshake edge must not decrement hold-off
        add(1,1,5,1,1, 0,5,1);
        addn(7, 1,1,5,1,1, 0,5,1);
        add(1,1,5,1,1, 0,5,0);
        addn(6, 1,1,5,1,1, 0,5,0);
        // 2,2,2,4,4,4,4 with consumer stalled for 10 cycles
        addn(3, 1,1,2,1,0, 0,5,0);
        addn(3, 1,1,4,1,0, 0,5,0);
        add(1,1,4,1,0, 1,4,1);
        addn(10, 1,1,1,1,0, 1,4,1);
        add(1,0,0,0,1, 0,4,1);
        addn(7, 1,1,0,0,1, 0,4,1);
        add(1,1,0,0,1, 0,4,0);
        // finger_count 7 clamps to 5
        addn(3, 1,1,7,1,1, 0,4,0);
        add(1,1,7,1,1, 1,5,1);
        add(1,0,0,0,1, 0,5,1);
        addn(7, 1,1,6,1,1, 0,5,1);
        add(1,1,6,1,1, 0,5,0);
        // no hand x4 -> HOME
        addn(3, 1,1,3,0,1, 0,5,0);
        add(1,1,3,0,1, 1,7,1);
        add(1,0,0,0,1, 0,7,1);
        // disable during hold-off, frames ignored while idle
        add(0,0,0,0,1, 0,7,0);
        addn(4, 0,1,3,1,1, 0,7,0);
        add(1,0,0,0,1, 0,7,0);
        addn(3, 1,1,3,1,0, 0,7,0);
        add(1,1,3,1,0, 1,3,1);
        // disable during ISSUE: command held until accepted, then idle
        addn(2, 0,0,0,0,0, 1,3,1);
        add(0,0,0,0,1, 0,3,0);
        add(0,0,0,0,1, 0,3,0);
        // issue 2 so the watchdog has a non-HOME last command
        add(1,0,0,0,1, 0,3,0);
        addn(3, 1,1,2,1,1, 0,3,0);
        add(1,1,2,1,1, 1,2,1);
        add(1,0,0,0,1, 0,2,1);

        rst_n = 1'b0; enable = 1'b0; count_valid = 1'b0; finger_count = '0;
        hand_detected = 1'b0; cif.cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", cif.cmd_valid, 0);
        chk("rst_code", cif.cmd_code, 7);
        chk("rst_busy", busy, 0);
        chk("rst_flag", timeout_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].cv, vecs[i].fc, vecs[i].hd, vecs[i].rdy);
            chk($sformatf("v%0d_valid", i), cif.cmd_valid, vecs[i].ev);
            chk($sformatf("v%0d_code", i), cif.cmd_code, vecs[i].ec);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].eb);
            chk($sformatf("v%0d_flag", i), timeout_flag, 0);
        end

        // watchdog: no frames after the command-2 handshake, consumer stalled
        trip = 0; tv = 0; tc = 0;
        for (int n = 1; n <= 150; n++) begin
            drive(1, 0, 0, 0, 0);
            if (timeout_flag && trip == 0) begin
                trip = n; tv = cif.cmd_valid; tc = cif.cmd_code;
                break;
            end
        end
`ifdef GESTURE_WATCHDOG_EN
        chk("wd_trip_cycle", trip, 100);
        chk("wd_valid", tv, 1);
        chk("wd_code", tc, 7);
        drive(1, 0, 0, 0, 1);
        chk("wd_accept_valid", cif.cmd_valid, 0);
        chk("wd_flag_held", timeout_flag, 1);
        drive(1, 1, 3, 1, 1);
        chk("wd_flag_clear", timeout_flag, 0);
`else
        chk("wd_no_trip", trip, 0);
        chk("wd_no_cmd", cif.cmd_valid, 0);
        chk("wd_code_kept", cif.cmd_code, 2);
        chk("wd_flag_zero", timeout_flag, 0);
`endif

        // reset while a command is offered withdraws it
        drive(1, 0, 0, 0, 1);
        rst_n = 1'b1;
        repeat (20) drive(1, 1, 1, 1, 0);
        chk("pre_rst_valid", cif.cmd_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_drop_valid", cif.cmd_valid, 0);
        chk("rst_drop_code", cif.cmd_code, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
